sync_multiport_mem: RTL and testbench
=====================================

Name: sync_multiport_mem

Overview:
- Parametrised byte-addressed, word-organised memory. N write ports and M read ports, with byte-lane masks on writes.
- Reads are synchronous with a request/response handshake: one-cycle latency and a misalignment error flag.
- An optional reset-time clear FSM zeroes the array; all ports stall until it finishes.
- Serves as the shared instruction/data/host-loader backing store for the Sodor cores and the host interface.

Parameters:
- NUM_BYTES, 1<<21, total capacity in bytes; power of two.
- DATA_WIDTH, 32, word width in bits; multiple of 8; DATA_WIDTH/8 is a power of two.
- NUM_WR_PORTS, 2, number of write ports (≥1).
- NUM_RD_PORTS, 3, number of read ports (≥1).
- CLEAR_ON_RESET, 1, when 1 the array is zero-filled after reset before ports are accepted.
- WRITE_FORWARD, 0, when 1 a same-cycle write to the read word is forwarded into the response; when 0 the response carries old data.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- wr_en  in  NUM_WR_PORTS  per-port write strobe.
- wr_addr  in  NUM_WR_PORTS*ADDR_WIDTH  byte address.
- wr_data  in  NUM_WR_PORTS*DATA_WIDTH  write data.
- wr_mask  in  NUM_WR_PORTS*MASK_WIDTH  byte-lane enables.
- wr_err  out  NUM_WR_PORTS  one-cycle pulse: the previous write was misaligned and was dropped.
- rd_req_valid  in  NUM_RD_PORTS  read request.
- rd_req_addr  in  NUM_RD_PORTS*ADDR_WIDTH  byte address.
- rd_resp_valid  out  NUM_RD_PORTS  response valid, one cycle after the accepted request.
- rd_resp_data  out  NUM_RD_PORTS*DATA_WIDTH  read data.
- rd_resp_err  out  NUM_RD_PORTS  the request was misaligned; data is zero.
- ready  out  1  ports accept requests; common to all ports.
- init_done  out  1  clear sequence complete; level signal.

Behaviour:
- Derived widths:
  - ADDR_WIDTH = $clog2(NUM_BYTES)
  - MASK_WIDTH = DATA_WIDTH/8
  - OFF_W = $clog2(MASK_WIDTH)
  - DEPTH = NUM_BYTES/MASK_WIDTH
  - word index = addr[ADDR_WIDTH-1:OFF_W]; byte lane i maps to data[8i+7:8i].
- FSM states: INIT, RUN.
  - Reset → INIT if CLEAR_ON_RESET, else RUN.
  - INIT writes zero to word clr_cnt each cycle, clr_cnt counting 0..DEPTH-1.
  - INIT → RUN after writing word DEPTH-1, so INIT lasts exactly DEPTH cycles after reset deassertion.
- ready = (state==RUN); init_done = (state==RUN).
- During INIT, wr_en and rd_req_valid are ignored: no array update, no response, no error.
- Reset values: state as above; clr_cnt=0; rd_resp_valid=0; rd_resp_err=0; rd_resp_data=0; wr_err=0. Array contents are not reset; they are only cleared by INIT.
- Reset asserted mid-INIT or mid-RUN: all outputs drop to reset values immediately (asynchronous); INIT restarts from word 0; any in-flight response is discarded.
- Writes in RUN:
  - An accepted write with addr[OFF_W-1:0]==0 updates the enabled lanes at the clock edge.
  - A misaligned write is dropped and wr_err[p]=1 on the next cycle.
  - wr_mask==0 is a legal no-op.
  - Two ports writing the same word and same lane: the higher port index wins, lane by lane. Non-overlapping lanes from different ports all land.
- Reads in RUN:
  - Request accepted when rd_req_valid & ready. The next cycle gives rd_resp_valid=1 and the data of the word at the sampling edge.
  - With WRITE_FORWARD=1, lanes written in the same cycle by accepted writes (after port priority) are substituted into the response.
  - Misaligned read: rd_resp_valid=1, rd_resp_err=1, data=0.
  - No request: rd_resp_valid=0, and rd_resp_data holds its last value.
  - Responses have no backpressure; a port may issue back-to-back every cycle.
- The addr-to-word mapping wraps naturally; there is no out-of-range case, since ADDR_WIDTH exactly spans NUM_BYTES.

Decomposition:
- Package sync_mem_pkg holds:
  - the derivation functions for ADDR_WIDTH, MASK_WIDTH, OFF_W and DEPTH;
  - the state enum (INIT, RUN);
  - a function that merges masked write data and returns the merged word.
- Sub-module mem_write_arbiter: combines all write ports plus the clear port into one per-lane write enable and data set per word. It is reused for the forwarding computation.

Test Plan (NUM_BYTES=64, DATA_WIDTH=32, 2 write ports, 3 read ports, CLEAR_ON_RESET=1, DEPTH=16):
- Release reset → ready=0 for 16 cycles, then ready=init_done=1. A read of 0x3C then returns 0x00000000 with err=0.
- RUN: write port 0 writes addr 0x08 with 0xDEADBEEF, mask 0xF; read port 1 reads 0x08 on the next cycle → the following cycle gives rd_resp_valid[1]=1 and data 0xDEADBEEF.
- Same cycle: port 0 writes 0x10 with 0x11111111 mask 0xF; port 1 writes 0x10 with 0x22222222 mask 0x3 → a later read gives 0x11112222.
- WRITE_FORWARD=0: read 0x08 in the same cycle as a write of 0xCAFEF00D → response is 0xDEADBEEF. With WRITE_FORWARD=1 the response is 0xCAFEF00D.
- Read of 0x0A → rd_resp_err=1, data=0. Write to 0x05 → wr_err=1 next cycle, and the array is unchanged.
- Assert reset while a read response is pending in RUN → rd_resp_valid=0 immediately. After release, INIT repeats for 16 cycles, and previously written words read back as 0.

Source files
------------

// File: rtl/sync_mem_pkg.sv
// Shared types and helpers for the multiport word memory: width derivations,
// the clear/run state encoding and the byte-lane merge used by every write path.
package sync_mem_pkg;

  localparam int MAX_DATA_WIDTH = 512;
  localparam int MAX_MASK_WIDTH = MAX_DATA_WIDTH / 8;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  function automatic int calc_addr_width(input int num_bytes);
    return $clog2(num_bytes);
  endfunction

  function automatic int calc_mask_width(input int data_width);
    return data_width / 8;
  endfunction

  function automatic int calc_off_width(input int mask_width);
    return $clog2(mask_width);
  endfunction

  function automatic int calc_depth(input int num_bytes, input int mask_width);
    return num_bytes / mask_width;
  endfunction

  // Callers zero-extend narrower words into the max width and truncate the result.
  function automatic logic [MAX_DATA_WIDTH-1:0] merge_word(
    input logic [MAX_DATA_WIDTH-1:0] old_word,
    input logic [MAX_DATA_WIDTH-1:0] new_word,
    input logic [MAX_MASK_WIDTH-1:0] mask
  );
    logic [MAX_DATA_WIDTH-1:0] result;
    result = old_word;
    for (int i = 0; i < MAX_MASK_WIDTH; i++) begin
      if (mask[i]) result[i*8 +: 8] = new_word[i*8 +: 8];
    end
    return result;
  endfunction

endpackage

// File: rtl/mem_write_arbiter.sv
// Resolves all write ports plus the clear port against one queried word index,
// giving the per-lane enables and data that land there (higher port index wins).
module mem_write_arbiter
  import sync_mem_pkg::*;
#(
  parameter int NUM_PORTS  = 2,
  parameter int DATA_WIDTH = 32,
  parameter int IDX_WIDTH  = 4,
  localparam int MASK_WIDTH = calc_mask_width(DATA_WIDTH)
) (
  input  logic [IDX_WIDTH-1:0]            query_idx,
  input  logic                            clr_en,
  input  logic [IDX_WIDTH-1:0]            clr_idx,
  input  logic [NUM_PORTS-1:0]            wr_go,
  input  logic [NUM_PORTS*IDX_WIDTH-1:0]  wr_idx,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] wr_data,
  input  logic [NUM_PORTS*MASK_WIDTH-1:0] wr_mask,
  output logic [MASK_WIDTH-1:0]           lane_en,
  output logic [DATA_WIDTH-1:0]           lane_data
);

  always_comb begin
    lane_en   = '0;
    lane_data = '0;
    if (clr_en && clr_idx == query_idx) lane_en = '1;
    // Ascending port order lets later (higher) ports overwrite shared lanes.
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (wr_go[p] && wr_idx[p*IDX_WIDTH +: IDX_WIDTH] == query_idx) begin
        lane_data = DATA_WIDTH'(merge_word(MAX_DATA_WIDTH'(lane_data),
                                           MAX_DATA_WIDTH'(wr_data[p*DATA_WIDTH +: DATA_WIDTH]),
                                           MAX_MASK_WIDTH'(wr_mask[p*MASK_WIDTH +: MASK_WIDTH])));
        lane_en   = lane_en | wr_mask[p*MASK_WIDTH +: MASK_WIDTH];
      end
    end
  end

endmodule

// File: rtl/sync_multiport_mem.sv
// Byte-addressed, word-organised memory with N masked write ports, M synchronous
// read ports and an optional zero-fill sequence after reset that stalls all ports.
module sync_multiport_mem
  import sync_mem_pkg::*;
#(
  parameter int NUM_BYTES      = 1 << 21,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_WR_PORTS   = 2,
  parameter int NUM_RD_PORTS   = 3,
  parameter bit CLEAR_ON_RESET = 1'b1,
  parameter bit WRITE_FORWARD  = 1'b0,
  localparam int ADDR_WIDTH = calc_addr_width(NUM_BYTES),
  localparam int MASK_WIDTH = calc_mask_width(DATA_WIDTH),
  localparam int OFF_W      = calc_off_width(MASK_WIDTH),
  localparam int DEPTH      = calc_depth(NUM_BYTES, MASK_WIDTH)
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_WR_PORTS-1:0]            wr_en,
  input  logic [NUM_WR_PORTS*ADDR_WIDTH-1:0] wr_addr,
  input  logic [NUM_WR_PORTS*DATA_WIDTH-1:0] wr_data,
  input  logic [NUM_WR_PORTS*MASK_WIDTH-1:0] wr_mask,
  output logic [NUM_WR_PORTS-1:0]            wr_err,
  input  logic [NUM_RD_PORTS-1:0]            rd_req_valid,
  input  logic [NUM_RD_PORTS*ADDR_WIDTH-1:0] rd_req_addr,
  output logic [NUM_RD_PORTS-1:0]            rd_resp_valid,
  output logic [NUM_RD_PORTS*DATA_WIDTH-1:0] rd_resp_data,
  output logic [NUM_RD_PORTS-1:0]            rd_resp_err,
  output logic                               ready,
  output logic                               init_done
);

  localparam int IDX_W     = ADDR_WIDTH - OFF_W;
  localparam int NUM_SLOTS = NUM_WR_PORTS + 1;
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'(MASK_WIDTH - 1);

  state_e            state;
  logic [IDX_W-1:0]  clr_cnt;
  logic              run;
  logic              clr_en;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  assign run       = (state == RUN);
  assign clr_en    = (state == INIT);
  assign ready     = run;
  assign init_done = run;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= CLEAR_ON_RESET ? INIT : RUN;
      clr_cnt <= '0;
    end else if (state == INIT) begin
      clr_cnt <= clr_cnt + 1'b1;
      if (clr_cnt == IDX_W'(DEPTH - 1)) state <= RUN;
    end
  end

  logic [NUM_WR_PORTS-1:0]       wr_aligned;
  logic [NUM_WR_PORTS-1:0]       wr_go;
  logic [NUM_WR_PORTS*IDX_W-1:0] wr_idx;

  for (genvar p = 0; p < NUM_WR_PORTS; p++) begin : g_wr
    assign wr_aligned[p] = (wr_addr[p*ADDR_WIDTH +: ADDR_WIDTH] & OFF_MASK) == '0;
    assign wr_idx[p*IDX_W +: IDX_W] = IDX_W'(wr_addr[p*ADDR_WIDTH +: ADDR_WIDTH] >> OFF_W);
    assign wr_go[p] = run & wr_en[p] & wr_aligned[p];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) wr_err <= '0;
    else       wr_err <= run ? (wr_en & ~wr_aligned) : '0;
  end

  // One slot per write port plus the clear port; slots hitting the same word
  // resolve to the same merged value, so duplicate updates are harmless.
  logic [IDX_W-1:0]      slot_idx  [NUM_SLOTS];
  logic [MASK_WIDTH-1:0] slot_en   [NUM_SLOTS];
  logic [DATA_WIDTH-1:0] slot_data [NUM_SLOTS];
  logic [DATA_WIDTH-1:0] slot_word [NUM_SLOTS];

  for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_slot
    if (s < NUM_WR_PORTS) begin : g_port
      assign slot_idx[s] = wr_idx[s*IDX_W +: IDX_W];
    end else begin : g_clear
      assign slot_idx[s] = clr_cnt;
    end
    mem_write_arbiter #(
      .NUM_PORTS (NUM_WR_PORTS),
      .DATA_WIDTH(DATA_WIDTH),
      .IDX_WIDTH (IDX_W)
    ) u_arb (
      .query_idx(slot_idx[s]),
      .clr_en   (clr_en),
      .clr_idx  (clr_cnt),
      .wr_go    (wr_go),
      .wr_idx   (wr_idx),
      .wr_data  (wr_data),
      .wr_mask  (wr_mask),
      .lane_en  (slot_en[s]),
      .lane_data(slot_data[s])
    );
    assign slot_word[s] = DATA_WIDTH'(merge_word(MAX_DATA_WIDTH'(mem[slot_idx[s]]),
                                                 MAX_DATA_WIDTH'(slot_data[s]),
                                                 MAX_MASK_WIDTH'(slot_en[s])));
  end

  always_ff @(posedge clk) begin
    for (int s = 0; s < NUM_SLOTS; s++) begin
      if (|slot_en[s]) mem[slot_idx[s]] <= slot_word[s];
    end
  end

  for (genvar r = 0; r < NUM_RD_PORTS; r++) begin : g_rd
    logic [ADDR_WIDTH-1:0] addr;
    logic [IDX_W-1:0]      idx;
    logic                  aligned;
    logic [DATA_WIDTH-1:0] word;
    logic                  resp_valid;
    logic                  resp_err;
    logic [DATA_WIDTH-1:0] resp_data;

    assign addr    = rd_req_addr[r*ADDR_WIDTH +: ADDR_WIDTH];
    assign idx     = IDX_W'(addr >> OFF_W);
    assign aligned = (addr & OFF_MASK) == '0;

    if (WRITE_FORWARD) begin : g_fwd
      logic [MASK_WIDTH-1:0] fwd_en;
      logic [DATA_WIDTH-1:0] fwd_data;
      mem_write_arbiter #(
        .NUM_PORTS (NUM_WR_PORTS),
        .DATA_WIDTH(DATA_WIDTH),
        .IDX_WIDTH (IDX_W)
      ) u_fwd_arb (
        .query_idx(idx),
        .clr_en   (clr_en),
        .clr_idx  (clr_cnt),
        .wr_go    (wr_go),
        .wr_idx   (wr_idx),
        .wr_data  (wr_data),
        .wr_mask  (wr_mask),
        .lane_en  (fwd_en),
        .lane_data(fwd_data)
      );
      assign word = DATA_WIDTH'(merge_word(MAX_DATA_WIDTH'(mem[idx]),
                                           MAX_DATA_WIDTH'(fwd_data),
                                           MAX_MASK_WIDTH'(fwd_en)));
    end else begin : g_nofwd
      assign word = mem[idx];
    end

    // Data holds its last value when idle; valid and err pulse with each response.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        resp_valid <= 1'b0;
        resp_err   <= 1'b0;
        resp_data  <= '0;
      end else if (rd_req_valid[r] && run) begin
        resp_valid <= 1'b1;
        resp_err   <= ~aligned;
        resp_data  <= aligned ? word : '0;
      end else begin
        resp_valid <= 1'b0;
        resp_err   <= 1'b0;
      end
    end

    assign rd_resp_valid[r] = resp_valid;
    assign rd_resp_err[r]   = resp_err;
    assign rd_resp_data[r*DATA_WIDTH +: DATA_WIDTH] = resp_data;
  end

endmodule

// File: tb/tb_sync_multiport_mem.sv
// Drives two identically-stimulated memories (no forwarding / forwarding) and
// compares both against a byte-array model of the memory.
module tb_sync_multiport_mem;

  localparam int NB = 64;
  localparam int AW = 6;
  localparam int DW = 32;
  localparam int MW = 4;
  localparam int NWR = 2;
  localparam int NRD = 3;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic reset;
  logic [NWR-1:0]    wr_en;
  logic [NWR*AW-1:0] wr_addr;
  logic [NWR*DW-1:0] wr_data;
  logic [NWR*MW-1:0] wr_mask;
  logic [NRD-1:0]    rd_req_valid;
  logic [NRD*AW-1:0] rd_req_addr;

  logic [NWR-1:0]    wr_err_a, wr_err_b;
  logic [NRD-1:0]    rv_a, re_a, rv_b, re_b;
  logic [NRD*DW-1:0] rd_a, rd_b;
  logic              ready_a, init_a, ready_b, init_b;

  logic [7:0]  ref_bytes [NB];
  logic [31:0] last_a [NRD];
  logic [31:0] last_b [NRD];
  int n_checks = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  sync_multiport_mem #(.NUM_BYTES(NB), .DATA_WIDTH(DW), .NUM_WR_PORTS(NWR), .NUM_RD_PORTS(NRD),
                       .CLEAR_ON_RESET(1'b1), .WRITE_FORWARD(1'b0)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_mask(wr_mask), .wr_err(wr_err_a), .rd_req_valid(rd_req_valid),
    .rd_req_addr(rd_req_addr), .rd_resp_valid(rv_a), .rd_resp_data(rd_a),
    .rd_resp_err(re_a), .ready(ready_a), .init_done(init_a)
  );

  sync_multiport_mem #(.NUM_BYTES(NB), .DATA_WIDTH(DW), .NUM_WR_PORTS(NWR), .NUM_RD_PORTS(NRD),
                       .CLEAR_ON_RESET(1'b1), .WRITE_FORWARD(1'b1)) dut_fwd (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_mask(wr_mask), .wr_err(wr_err_b), .rd_req_valid(rd_req_valid),
    .rd_req_addr(rd_req_addr), .rd_resp_valid(rv_b), .rd_resp_data(rd_b),
    .rd_resp_err(re_b), .ready(ready_b), .init_done(init_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic [31:0] ref_read(input int a);
    int base;
    base = (a / 4) * 4;
    return {ref_bytes[base+3], ref_bytes[base+2], ref_bytes[base+1], ref_bytes[base]};
  endfunction

  task automatic reset_model();
    for (int i = 0; i < NB; i++) ref_bytes[i] = 8'h00;
    for (int r = 0; r < NRD; r++) begin
      last_a[r] = '0;
      last_b[r] = '0;
    end
  endtask

  task automatic idle();
    wr_en = '0; wr_addr = '0; wr_data = '0; wr_mask = '0;
    rd_req_valid = '0; rd_req_addr = '0;
  endtask

  task automatic drive_write(input int p, input int a, input logic [31:0] d, input logic [3:0] m);
    wr_en[p] = 1'b1;
    wr_addr[p*AW +: AW] = AW'(a);
    wr_data[p*DW +: DW] = d;
    wr_mask[p*MW +: MW] = m;
  endtask

  task automatic drive_read(input int r, input int a);
    rd_req_valid[r] = 1'b1;
    rd_req_addr[r*AW +: AW] = AW'(a);
  endtask

  // One RUN cycle: predict from the model, clock, then compare both memories.
  task automatic do_cycle();
    logic exp_v [NRD];
    logic exp_e [NRD];
    logic [NWR-1:0] exp_werr;
    int a;
    for (int r = 0; r < NRD; r++) begin
      a = int'(rd_req_addr[r*AW +: AW]);
      exp_v[r] = rd_req_valid[r];
      exp_e[r] = rd_req_valid[r] && (a % 4 != 0);
      if (rd_req_valid[r]) last_a[r] = exp_e[r] ? 32'h0 : ref_read(a);
    end
    for (int p = 0; p < NWR; p++) begin
      a = int'(wr_addr[p*AW +: AW]);
      exp_werr[p] = wr_en[p] && (a % 4 != 0);
      if (wr_en[p] && a % 4 == 0)
        for (int l = 0; l < MW; l++)
          if (wr_mask[p*MW + l]) ref_bytes[a + l] = wr_data[p*DW + l*8 +: 8];
    end
    for (int r = 0; r < NRD; r++) begin
      a = int'(rd_req_addr[r*AW +: AW]);
      if (rd_req_valid[r]) last_b[r] = exp_e[r] ? 32'h0 : ref_read(a);
    end
    @(posedge clk);
    @(negedge clk);
    for (int r = 0; r < NRD; r++) begin
      check($sformatf("rd_valid[%0d]", r), rv_a[r], exp_v[r]);
      check($sformatf("rd_err[%0d]", r), re_a[r], exp_e[r]);
      check($sformatf("rd_data[%0d]", r), rd_a[r*DW +: DW], last_a[r]);
      check($sformatf("fwd_valid[%0d]", r), rv_b[r], exp_v[r]);
      check($sformatf("fwd_data[%0d]", r), rd_b[r*DW +: DW], last_b[r]);
    end
    check("wr_err", wr_err_a, exp_werr);
    check("fwd_wr_err", wr_err_b, exp_werr);
    idle();
  endtask

  // Counts INIT cycles from a negedge just after reset release, with random
  // requests that must all be ignored.
  task automatic wait_init();
    int cnt;
    logic seen;
    cnt = 0;
    seen = 1'b0;
    while (ready_a !== 1'b1 && cnt < 100) begin
      wr_en = NWR'($urandom); wr_addr = (NWR*AW)'($urandom);
      wr_data = {$urandom, $urandom}; wr_mask = (NWR*MW)'($urandom);
      rd_req_valid = NRD'($urandom); rd_req_addr = (NRD*AW)'($urandom);
      @(posedge clk);
      @(negedge clk);
      cnt++;
      seen = seen | (|rv_a) | (|rv_b) | (|wr_err_a) | (|wr_err_b) | (ready_b !== ready_a);
    end
    idle();
    check("init_cycles", cnt, DEPTH);
    check("init_quiet", seen, 0);
    check("ready", ready_a, 1);
    check("init_done", init_a, 1);
    check("fwd_init_done", init_b, 1);
  endtask

  initial begin
    idle();
    reset_model();
    reset = 1'b0;
    #1 reset = 1'b1;
    #1;
    check("rst_ready", ready_a, 0);
    check("rst_init_done", init_a, 0);
    check("rst_rd_valid", rv_a, 0);
    check("rst_rd_data", rd_a[31:0], 0);
    check("rst_wr_err", wr_err_a, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    wait_init();

    drive_read(0, 'h3C); do_cycle();
    check("rd_3c", rd_a[31:0], 32'h0);
    check("rd_3c_err", re_a[0], 0);

    drive_write(0, 'h08, 32'hDEADBEEF, 4'hF); do_cycle();
    drive_read(1, 'h08); do_cycle();
    check("rd_08_valid", rv_a[1], 1);
    check("rd_08", rd_a[63:32], 32'hDEADBEEF);

    drive_write(0, 'h10, 32'h11111111, 4'hF);
    drive_write(1, 'h10, 32'h22222222, 4'h3); do_cycle();
    drive_read(2, 'h10); do_cycle();
    check("port_prio", rd_a[95:64], 32'h11112222);

    drive_write(0, 'h08, 32'hCAFEF00D, 4'hF);
    drive_read(0, 'h08); do_cycle();
    check("no_forward", rd_a[31:0], 32'hDEADBEEF);
    check("forward", rd_b[31:0], 32'hCAFEF00D);

    drive_read(1, 'h0A); do_cycle();
    check("misaligned_rd_err", re_a[1], 1);
    check("misaligned_rd_data", rd_a[63:32], 32'h0);
    drive_write(0, 'h05, 32'hFFFFFFFF, 4'hF); do_cycle();
    check("misaligned_wr_err", wr_err_a[0], 1);
    drive_read(0, 'h04); do_cycle();
    check("misaligned_wr_dropped", rd_a[31:0], 32'h0);

    drive_write(1, 'h08, 32'h12345678, 4'h0); do_cycle();
    drive_read(2, 'h08); do_cycle();
    check("mask_zero_noop", rd_a[95:64], 32'hCAFEF00D);

    // Reset with a response outstanding: it must vanish asynchronously.
    drive_read(0, 'h08);
    @(posedge clk);
    #2;
    check("pending_valid", rv_a[0], 1);
    reset = 1'b1;
    #1;
    check("async_rst_valid", rv_a[0], 0);
    check("async_rst_ready", ready_a, 0);
    check("async_rst_data", rd_a[31:0], 0);
    idle();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    reset_model();
    wait_init();
    drive_read(0, 'h08); drive_read(1, 'h10); do_cycle();
    check("cleared_08", rd_a[31:0], 32'h0);
    check("cleared_10", rd_a[63:32], 32'h0);

    for (int i = 0; i < 300; i++) begin
      for (int p = 0; p < NWR; p++) begin
        int a;
        a = $urandom_range(0, NB - 1);
        if ($urandom_range(0, 3) != 0) a = (a / 4) * 4;
        if ($urandom_range(0, 1) == 1) drive_write(p, a, $urandom, 4'($urandom_range(0, 15)));
      end
      for (int r = 0; r < NRD; r++) begin
        int a;
        a = $urandom_range(0, NB - 1);
        if ($urandom_range(0, 4) != 0) a = (a / 4) * 4;
        if ($urandom_range(0, 2) != 0) drive_read(r, a);
      end
      do_cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
